fetch_queue: RTL

Instruction fetch queue between the IF stage and the ID stage of the LoongArch pipeline. Accepts {pc, instruction, fetch-exception} words from fetch over a valid/ready handshake, buffers them in a DEPTH-entry circular FIFO, and presents the head entry as `instrD`/`pcD` to decode. Decode feeds `instrD` to the immediate extender and the control decoder. A branch/exception redirect flushes the queue in one cycle.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 86 ++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The queue takes the slave view; the fetch/decode side takes the master view.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic          if_adef;
  logic          if_ready;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   pcD;
  logic [31:0]   instrD;
  logic          adefD;
  logic [CW-1:0] count;

  modport master (
    output flush, if_valid, if_pc, if_instr, if_adef, id_ready,
    input  if_ready, id_valid, pcD, instrD, adefD, count
  );

  modport slave (
    input  flush, if_valid, if_pc, if_instr, if_adef, id_ready,
    output if_ready, id_valid, pcD, instrD, adefD, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: DEPTH-entry circular FIFO with
// show-ahead head outputs and a single-cycle flush on redirect.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0340_0000
) (
  input  logic         clk,
  input  logic         rstn,
  fetch_queue_if.slave fq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic          mem_adef  [DEPTH];

  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head_valid;

  always_comb begin
    full       = (count == CW'(DEPTH));
    empty      = (count == '0);
    // if_ready ignores id_ready on purpose: no pass-through while full
    push       = fq.if_valid && !full && !fq.flush;
    head_valid = !empty && !fq.flush;
    pop        = head_valid && fq.id_ready;
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else if (fq.flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count_next;
    end
  end

  // Storage carries no reset; stale contents are masked by head_valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wp]    <= fq.if_pc;
      mem_instr[wp] <= fq.if_instr;
      mem_adef[wp]  <= fq.if_adef;
    end
  end

  always_comb begin
    fq.if_ready = !full;
    fq.id_valid = head_valid;
    fq.count    = count;
    if (head_valid) begin
      fq.pcD    = mem_pc[rp];
      fq.instrD = mem_instr[rp];
      fq.adefD  = mem_adef[rp];
    end else begin
      fq.pcD    = '0;
      fq.instrD = NOP_INSTR;
      fq.adefD  = 1'b0;
    end
  end
endmodule
